mmio_controller: RTL
====================

Name: mmio_controller

Overview:
- Owns the memory-mapped I/O window at 0x0003_0000 between the hart and the board peripherals.
- Decodes the hart's MMIO write requests and generates the write-complete handshake.
- Buffers UART bytes in a small FIFO and sequences them into serial_transmitter.
- Holds the LED control registers and serves a read-only status register, so that stores to the UART no longer stall for a whole character time.

Parameters:
- BASE_ADDR, 32'h0003_0000: base of the 16-byte MMIO window.
- TX_FIFO_DEPTH, 8: UART byte FIFO depth; must be a power of two, at least 2.

Ports:
- core_clock  in  1  core clock
- reset  in  1  reset, synchronous, active-high
- mmio_control  in  mem_write_control_t  hart write request (addr, width, value, enable)
- mmio_read_addr  in  32  hart MMIO load address
- mmio_r_data  out  32  load data, combinational from mmio_read_addr
- mmio_write_complete  out  1  one-cycle acknowledge of the current write request
- serial_tx_data  out  8  byte offered to serial_transmitter
- serial_tx_data_available  out  1  offer valid
- serial_tx_ready  in  1  transmitter idle; falls when it latches a byte
- led_blue_control  out  1  blue LED enable
- led_green_control  out  1  green LED enable

Behaviour:
- Register map (offsets from BASE_ADDR):
  - +0x0 TXDATA: write-only, byte-wide.
  - +0x4 LED_BLUE: read/write, bit0.
  - +0x8 LED_GREEN: read/write, bit0.
  - +0xC STATUS: read; any write clears the sticky bits.
- STATUS layout:
  - bit0: fifo_empty.
  - bit1: fifo_full.
  - bit2: sticky width_err.
  - bits[7:4]: fifo level, saturating at 15.
  - all other bits 0.
- Reads: TXDATA and unmapped addresses return 0.
- Reset values: every output 0; FIFO empty; sticky bits 0; both FSMs idle.
- Write-accept FSM, states ACCEPT and ACK:
  - ACCEPT: a request is pending when mmio_control.enable=1. It is accepted in the same cycle unless it targets TXDATA, is byte-wide, and the FIFO is full. That case stalls, with no acknowledge, until the FIFO has space.
  - On accept: perform the side effect, then go to ACK.
  - ACK: mmio_write_complete=1 for exactly that one cycle; enable is ignored; return to ACCEPT.
  - Acknowledge latency is therefore 1 cycle after accept.
  - The hart drops enable or presents its next request in the cycle after the acknowledge.
- Side effects at accept:
  - TXDATA, width=write_byte: push value[7:0].
  - TXDATA, other width: no push; set width_err; still acknowledged.
  - LED_BLUE / LED_GREEN: register <= (value != 0).
  - STATUS: clear width_err.
  - Unmapped address inside or outside the window: acknowledged, no effect, so the hart can never hang.
- Push is allowed only when the registered fifo_full is 0. A simultaneous pop does not enable a push in the same cycle.
- TX drain FSM, states TX_IDLE, TX_OFFER and TX_BUSY:
  - TX_IDLE: if the FIFO is non-empty, go to TX_OFFER.
  - TX_OFFER: serial_tx_data = FIFO head, serial_tx_data_available=1. Hold both stable until serial_tx_ready=0 is sampled; then pop the FIFO, deassert available, go to TX_BUSY.
  - TX_BUSY: wait for serial_tx_ready=1, then go to TX_IDLE.
  - One pop per transmitted byte; bytes leave in FIFO order.
- Push and pop in the same cycle are both honoured; the level is unchanged.
- FIFO pointers are log2(depth)+1 bits wide and wrap naturally. Full means the MSBs differ and the remaining bits are equal.
- Reset mid-operation:
  - Returns to the reset state within one cycle and discards FIFO contents.
  - Any acknowledge pending in ACK is dropped.
  - A byte already latched by the transmitter finishes under the transmitter's own reset rules.

Decomposition:
- Shared package, extending the existing ISA types package:
  - MMIO_BASE and the four register offset constants.
  - A status bit-position enum.
  - mem_write_control_t stays where it already lives.
- One sub-module: sync_fifo, parameterised by width and depth. It has push/pop/full/empty/level ports and no show-ahead latency (head valid whenever non-empty).
- Both FSMs and the register decode live in mmio_controller.

Test Plan:
- Single byte: write_byte 0x41 to 0x0003_0000 → complete pulses one cycle after enable. Available rises within 2 cycles with data 0x41. The model drops tx_ready → available falls next cycle, STATUS reads 0x0000_0001.
- Burst of 9 bytes, depth 8, transmitter model held busy → bytes 1–8 acknowledged back-to-back (accept/ACK). Byte 9 gets no complete while STATUS=0x0000_0082. Releasing one byte → byte 9 completes. Output order is 1..9.
- LED writes: 0x0000_0005 to +0x4, then 0 to +0x8 → led_blue=1, led_green=0, reads return 1 and 0. Writing 0 to +0x4 → led_blue=0.
- Word write to TXDATA → acknowledged, no FIFO push, STATUS bit2=1. Any write to +0xC → bit2=0. Write to 0x0003_0010 → acknowledged, no state change.
- Reset asserted with 3 bytes queued and available=1 → next cycle available=0, complete=0, STATUS=0x0000_0001, LEDs 0.
- Enable held high through the acknowledge cycle → the same request is not double-accepted in ACK. It is re-accepted only if still present in the following ACCEPT cycle, which the checker flags as a protocol violation.

Source files
------------

// File: rtl/mmio_controller_pkg.sv
// mmio_controller_pkg
//   Shared types for the MMIO window: hart write-request struct, register
//   map constants, STATUS bit positions and the controller FSM encodings.
package mmio_controller_pkg;

   typedef enum logic [1:0] {
      write_byte = 2'd0,
      write_half = 2'd1,
      write_word = 2'd2
   } mem_write_width_t;

   typedef struct packed {
      logic [31:0]      addr;
      mem_write_width_t width;
      logic [31:0]      value;
      logic             enable;
   } mem_write_control_t;

   localparam logic [31:0] MMIO_BASE     = 32'h0003_0000;
   localparam logic [31:0] OFF_TXDATA    = 32'h0;
   localparam logic [31:0] OFF_LED_BLUE  = 32'h4;
   localparam logic [31:0] OFF_LED_GREEN = 32'h8;
   localparam logic [31:0] OFF_STATUS    = 32'hC;

   typedef enum int unsigned {
      STAT_FIFO_EMPTY = 0,
      STAT_FIFO_FULL  = 1,
      STAT_WIDTH_ERR  = 2,
      STAT_LEVEL_LSB  = 4
   } status_bit_e;

   typedef enum logic {
      ACCEPT,
      ACK
   } wr_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_OFFER,
      TX_BUSY
   } tx_state_e;

   // STATUS reports the FIFO level in a 4-bit field, saturating at 15.
   function automatic logic [3:0] sat_level(input logic [31:0] level);
      return (level > 32'd15) ? 4'hF : level[3:0];
   endfunction

endpackage

// File: rtl/mmio_controller_if.sv
// mmio_controller_if
//   Hart-side MMIO bus.
//   mmio_control        : write request (addr, width, value, enable)
//   mmio_read_addr      : load address
//   mmio_r_data         : load data, combinational from mmio_read_addr
//   mmio_write_complete : one-cycle write acknowledge
import mmio_controller_pkg::*;

interface mmio_controller_if;
   mem_write_control_t mmio_control;
   logic [31:0]        mmio_read_addr;
   logic [31:0]        mmio_r_data;
   logic               mmio_write_complete;

   modport master (
      output mmio_control,
      output mmio_read_addr,
      input  mmio_r_data,
      input  mmio_write_complete
   );

   modport slave (
      input  mmio_control,
      input  mmio_read_addr,
      output mmio_r_data,
      output mmio_write_complete
   );
endinterface

// File: rtl/mmio_controller_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO, head valid whenever non-empty (no show-ahead latency).
//   core_clock, reset : clock, synchronous active-high reset
//   push_i, wdata_i   : write strobe / data (ignored when full)
//   pop_i             : remove head (ignored when empty)
//   rdata_o           : FIFO head
//   full_o, empty_o   : status from registered pointers
//   level_o           : number of stored entries
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     core_clock,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              do_push, do_pop;

   // Pointers carry one extra wrap bit: full when only the wrap bits differ.
   always_comb begin
      full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty_o  = (wr_ptr_q == rd_ptr_q);
      level_o  = wr_ptr_q - rd_ptr_q;
      rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge core_clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge core_clock) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/mmio_controller.sv
// mmio_controller
//   MMIO window (16 bytes at BASE_ADDR): UART TX byte FIFO, LED registers,
//   read-only STATUS. Writes are acknowledged one cycle after accept; a byte
//   store only stalls while the TX FIFO is full.
//   core_clock, reset        : clock, synchronous active-high reset
//   mmio                     : hart bus (slave side)
//   serial_tx_data/_available: byte offered to serial_transmitter
//   serial_tx_ready          : transmitter idle; falls when it latches a byte
//   led_blue/green_control   : LED enables
import mmio_controller_pkg::*;

module mmio_controller #(
   parameter logic [31:0] BASE_ADDR     = MMIO_BASE,
   parameter int unsigned TX_FIFO_DEPTH = 8
) (
   input  logic                core_clock,
   input  logic                reset,
   mmio_controller_if.slave    mmio,
   output logic [7:0]          serial_tx_data,
   output logic                serial_tx_data_available,
   input  logic                serial_tx_ready,
   output logic                led_blue_control,
   output logic                led_green_control
);
   wr_state_e  wr_state_q, wr_state_d;
   tx_state_e  tx_state_q, tx_state_d;
   logic       led_blue_q, led_blue_d;
   logic       led_green_q, led_green_d;
   logic       width_err_q, width_err_d;

   logic       hit_tx, hit_blue, hit_green, hit_status, is_byte, accept;
   logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_head;
   logic [$clog2(TX_FIFO_DEPTH):0] fifo_level;

   sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
      .core_clock (core_clock),
      .reset      (reset),
      .push_i     (fifo_push),
      .wdata_i    (mmio.mmio_control.value[7:0]),
      .pop_i      (fifo_pop),
      .rdata_o    (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .level_o    (fifo_level)
   );

   // Write decode; a byte store to a full FIFO is the only non-accept.
   always_comb begin
      hit_tx     = (mmio.mmio_control.addr == BASE_ADDR + OFF_TXDATA);
      hit_blue   = (mmio.mmio_control.addr == BASE_ADDR + OFF_LED_BLUE);
      hit_green  = (mmio.mmio_control.addr == BASE_ADDR + OFF_LED_GREEN);
      hit_status = (mmio.mmio_control.addr == BASE_ADDR + OFF_STATUS);
      is_byte    = (mmio.mmio_control.width == write_byte);
      accept     = (wr_state_q == ACCEPT) && mmio.mmio_control.enable &&
                   !(hit_tx && is_byte && fifo_full);
      fifo_push  = accept && hit_tx && is_byte;
   end

   // Write-accept FSM
   always_ff @(posedge core_clock) begin
      if (reset) wr_state_q <= ACCEPT;
      else       wr_state_q <= wr_state_d;
   end

   always_comb begin
      wr_state_d = wr_state_q;
      unique case (wr_state_q)
         ACCEPT: if (accept) wr_state_d = ACK;
         ACK:    wr_state_d = ACCEPT;
         default: wr_state_d = ACCEPT;
      endcase
   end

   always_comb begin
      mmio.mmio_write_complete = (wr_state_q == ACK);
   end

   // Register side effects at accept
   always_comb begin
      led_blue_d  = led_blue_q;
      led_green_d = led_green_q;
      width_err_d = width_err_q;
      if (accept) begin
         if (hit_blue)            led_blue_d  = (mmio.mmio_control.value != '0);
         if (hit_green)           led_green_d = (mmio.mmio_control.value != '0);
         if (hit_tx && !is_byte)  width_err_d = 1'b1;
         if (hit_status)          width_err_d = 1'b0;
      end
   end

   always_ff @(posedge core_clock) begin
      if (reset) begin
         led_blue_q  <= 1'b0;
         led_green_q <= 1'b0;
         width_err_q <= 1'b0;
      end else begin
         led_blue_q  <= led_blue_d;
         led_green_q <= led_green_d;
         width_err_q <= width_err_d;
      end
   end

   assign led_blue_control  = led_blue_q;
   assign led_green_control = led_green_q;

   // TX drain FSM
   always_ff @(posedge core_clock) begin
      if (reset) tx_state_q <= TX_IDLE;
      else       tx_state_q <= tx_state_d;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      unique case (tx_state_q)
         TX_IDLE:  if (!fifo_empty)      tx_state_d = TX_OFFER;
         TX_OFFER: if (!serial_tx_ready) tx_state_d = TX_BUSY;
         TX_BUSY:  if (serial_tx_ready)  tx_state_d = TX_IDLE;
         default:  tx_state_d = TX_IDLE;
      endcase
   end

   // The transmitter dropping ready while offered means it took the byte.
   always_comb begin
      serial_tx_data_available = (tx_state_q == TX_OFFER);
      serial_tx_data           = (tx_state_q == TX_OFFER) ? fifo_head : '0;
      fifo_pop                 = (tx_state_q == TX_OFFER) && !serial_tx_ready;
   end

   // Combinational read port
   always_comb begin
      mmio.mmio_r_data = '0;
      if (mmio.mmio_read_addr == BASE_ADDR + OFF_LED_BLUE) begin
         mmio.mmio_r_data[0] = led_blue_q;
      end else if (mmio.mmio_read_addr == BASE_ADDR + OFF_LED_GREEN) begin
         mmio.mmio_r_data[0] = led_green_q;
      end else if (mmio.mmio_read_addr == BASE_ADDR + OFF_STATUS) begin
         mmio.mmio_r_data[STAT_FIFO_EMPTY] = fifo_empty;
         mmio.mmio_r_data[STAT_FIFO_FULL]  = fifo_full;
         mmio.mmio_r_data[STAT_WIDTH_ERR]  = width_err_q;
         mmio.mmio_r_data[STAT_LEVEL_LSB +: 4] = sat_level(32'(fifo_level));
      end
   end
endmodule
